// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the RV32M iterative multiply/divide unit.
package ex_muldiv_pkg;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      DONE = ST_DONE
   } state_e;
endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude/sign extraction at accept, and final result negation.
module muldiv_sign_fix
   import ex_muldiv_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [63:0] raw,
   input  logic        neg,
   output logic [31:0] mag_a,
   output logic [31:0] mag_b,
   output logic        neg_res,
   output logic [63:0] fixed
);
   logic a_sgn, b_sgn, sa, sb;

   assign a_sgn = (op == F3_MUL) || (op == F3_MULH) || (op == F3_MULHSU)
                || (op == F3_DIV) || (op == F3_REM);
   assign b_sgn = (op == F3_MUL) || (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
   assign sa    = a_sgn & a[31];
   assign sb    = b_sgn & b[31];

   assign mag_a = sa ? (~a + 32'd1) : a;
   assign mag_b = sb ? (~b + 32'd1) : b;
   // Remainder follows the dividend only; product and quotient follow the sign difference.
   assign neg_res = (op[2] && op[1]) ? sa : (sa ^ sb);

   assign fixed = neg ? (~raw + 64'd1) : raw;
endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M mul/div for the EX stage: 32 cycles of shift-add or
// restoring shift-subtract, stalling the pipe until a one-cycle DONE.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_ex,
   input  logic [2:0]      mdu_op_ex,
   input  logic [XLEN-1:0] op_a_ex,
   input  logic [XLEN-1:0] op_b_ex,
   input  logic            flush_ex,
   output logic            stall_o,
   output logic            done_o,
   output logic            busy_o,
   output logic [XLEN-1:0] result_o
);
   state_e              state, state_nx;
   logic [CNT_W-1:0]    cnt;
   logic [2:0]          op_q;
   logic [2*XLEN-1:0]   acc, acc_nx;
   logic [XLEN-1:0]     opnd, result_q;
   logic                neg_q;

   logic [XLEN-1:0]     mag_a, mag_b, fast_res, final_res;
   logic                neg_res, accept, fast, last, div_zero, div_ovf;
   logic [XLEN:0]       sum, trial;
   logic [2*XLEN-1:0]   raw, fixed;

   muldiv_sign_fix u_sign (
      .op      (accept ? mdu_op_ex : op_q),
      .a       (op_a_ex),
      .b       (op_b_ex),
      .raw     (raw),
      .neg     (neg_q),
      .mag_a   (mag_a),
      .mag_b   (mag_b),
      .neg_res (neg_res),
      .fixed   (fixed)
   );

   assign accept   = rst_ni && (state == IDLE) && start_ex && !flush_ex;
   assign div_zero = mdu_op_ex[2] && (op_b_ex == '0);
   assign div_ovf  = ((mdu_op_ex == F3_DIV) || (mdu_op_ex == F3_REM))
                   && (op_a_ex == 32'h8000_0000) && (op_b_ex == 32'hFFFF_FFFF);
   assign fast     = div_zero || div_ovf;
   assign fast_res = div_zero ? (mdu_op_ex[1] ? op_a_ex : '1)
                              : (mdu_op_ex[1] ? '0 : 32'h8000_0000);
   assign last     = (cnt == CNT_W'(XLEN-1));

   // acc holds {hi,lo} of the product, or {remainder,dividend/quotient} when dividing.
   always_comb begin
      sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      trial  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      acc_nx = {sum, acc[XLEN-1:1]};
      if (op_q[2]) begin
         if (trial >= {1'b0, opnd}) begin
            trial  = trial - {1'b0, opnd};
            acc_nx = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         end else begin
            acc_nx = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
      end
   end

   assign raw       = op_q[2] ? {{XLEN{1'b0}}, (op_q[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0])}
                              : acc_nx;
   assign final_res = (op_q[2] || op_q == F3_MUL) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_ex && !flush_ex) state_nx = fast ? DONE : CALC;
         CALC:    if (flush_ex) state_nx = IDLE;
                  else if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= IDLE;
         cnt      <= '0;
         op_q     <= '0;
         acc      <= '0;
         opnd     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q  <= mdu_op_ex;
            neg_q <= neg_res;
            cnt   <= '0;
            acc   <= {{XLEN{1'b0}}, (mdu_op_ex[2] ? mag_a : mag_b)};
            opnd  <= mdu_op_ex[2] ? mag_b : mag_a;
            if (fast) result_q <= fast_res;
         end else if (state == CALC && !flush_ex) begin
            acc <= acc_nx;
            cnt <= cnt + CNT_W'(1);
            if (last) result_q <= final_res;
         end
      end
   end

   assign stall_o  = accept || (state == CALC);
   assign done_o   = (state == DONE) && !flush_ex;
   assign busy_o   = (state != IDLE);
   assign result_o = result_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed checks of ex_muldiv: latency, stall/done timing, sign rules, fast paths, flush, reset.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        stall, done, busy;
   logic [31:0] result;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   ex_muldiv dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_ex  (start),
      .mdu_op_ex (op),
      .op_a_ex   (a),
      .op_b_ex   (b),
      .flush_ex  (flush),
      .stall_o   (stall),
      .done_o    (done),
      .busy_o    (busy),
      .result_o  (result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue at cycle T (now), expect done_o exactly lat cycles later with stall_o high until then.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp, input int lat);
      int n = 0;
      bit seen = 0, stall_ok = 1;
      start = 1'b1; op = f3; a = va; b = vb;
      while (!seen && n < 60) begin
         #3;
         if (done) seen = 1;
         else if (!stall) stall_ok = 0;
         if (!seen) begin
            tick;
            n++;
         end
      end
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      chk({tag, "_stall"}, {31'b0, stall_ok}, 32'd1);
      chk({tag, "_res"}, result, exp);
      chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
      tick;
      start = 1'b0;
      #3;
      chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
      tick;
   endtask

   initial begin
      bit seen;
      tick; tick;
      #3;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_res", result, 32'd0);
      rst_n = 1'b1;
      tick;

      run_op("mul",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulh",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
      run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op("div",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
      run_op("rem",    F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
      run_op("divu",   F3_DIVU,   32'd100,        32'd7,         32'd14,        33);
      run_op("remu",   F3_REMU,   32'd100,        32'd7,         32'd2,         33);
      run_op("div0",   F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
      run_op("rem0",   F3_REM,    32'd5,          32'd0,         32'd5,         1);
      run_op("divovf", F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("removf", F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

      // Flush a DIVU at T+10; a fresh MUL goes in at T+11.
      seen = 0;
      start = 1'b1; op = F3_DIVU; a = 32'd1000; b = 32'd3;
      for (int i = 0; i < 10; i++) begin
         #3;
         if (done) seen = 1;
         tick;
      end
      flush = 1'b1;
      #3;
      if (done) seen = 1;
      tick;
      flush = 1'b0; start = 1'b0;
      #3;
      chk("flush_busy", {31'b0, busy}, 32'd0);
      chk("flush_nodone", {31'b0, seen}, 32'd0);
      chk("flush_res", result, 32'd0);
      run_op("mul_after_flush", F3_MUL, 32'd3, 32'd4, 32'd12, 33);

      // Reset in the middle of a MUL, with start held through reset.
      start = 1'b1; op = F3_MUL; a = 32'd9; b = 32'd9;
      for (int i = 0; i < 5; i++) tick;
      rst_n = 1'b0;
      tick;
      #3;
      chk("mrst_stall", {31'b0, stall}, 32'd0);
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      chk("mrst_done", {31'b0, done}, 32'd0);
      chk("mrst_res", result, 32'd0);
      tick;
      rst_n = 1'b1; start = 1'b0;
      #3;
      chk("mrst_idle", {31'b0, busy}, 32'd0);
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-side operands and M-extension opcode.
- Holds the pipeline with a stall while computing.
- Presents a 32-bit result to the EX result mux for one cycle when finished.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold 0..XLEN.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  synchronous reset, active-low.
- start_ex  input  1  EX-stage instruction is an M-extension op.
- mdu_op_ex  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a_ex  input  32  rs1 operand (reg_1_ex).
- op_b_ex  input  32  rs2 operand (reg_2_ex).
- flush_ex  input  1  kills the EX-stage instruction.
- stall_o  output  1  hold IF/ID and ID/EX; do not advance EX.
- done_o  output  1  result_o valid this cycle.
- busy_o  output  1  FSM not in IDLE.
- result_o  output  32  final result.

Behaviour:
- Reset: the clock edge with rst_ni=0 forces state IDLE, counter 0, and all internal registers 0.
  - Outputs read 0 from the next cycle, regardless of mid-operation state.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Accept when start_ex=1 and flush_ex=0 (cycle T).
  - Latch op, operand magnitudes, sign flags and result-negate flag.
  - Normal ops go to CALC with counter=0.
  - Fast path goes directly to DONE at T+1 with the result precomputed:
    - DIV/DIVU by zero: result 0xFFFFFFFF.
    - REM/REMU by zero: result op_a.
    - DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000.
    - REM of the same operands: result 0.
- CALC: one iteration per cycle.
  - Multiply: shift-add on the unsigned magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and 32-bit remainder.
  - Leave after counter reaches 31, so CALC occupies T+1..T+32.
  - Enter DONE at T+33 with result_o registered.
- Sign rules:
  - MUL/MULH treat both operands as signed.
  - MULHSU treats a as signed, b as unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
  - Product is negated when operand signs differ (signed operands only).
  - Quotient is negated when dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - MUL returns product[31:0]; MULH* return product[63:32].
- DONE: lasts one cycle, then returns to IDLE.
  - done_o = (state==DONE) && !flush_ex.
- Stall (combinational): stall_o = (state==IDLE && start_ex && !flush_ex) || state==CALC.
  - stall_o is low in DONE so the instruction leaves EX with the result.
- No re-trigger: the same instruction is still on start_ex during DONE; it is not re-accepted because the FSM only samples start_ex in IDLE.
  - A following M-op is accepted in the next IDLE cycle.
- busy_o = (state != IDLE).
- result_o holds its last value until the next DONE entry.
- Flush:
  - flush_ex in CALC aborts to IDLE next cycle; no done_o and result_o is unchanged.
  - flush_ex in IDLE blocks acceptance.
- Reset beats flush, flush beats start.

Decomposition:
- Add `define constants for the funct3 M-op encodings and the MULDIV opcode/funct7 (7'b0000001) to rv32_opcodes.vh.
- FSM state encodings are localparams.
- One natural sub-module: muldiv_sign_fix, combinational.
  - Computes operand magnitudes and sign flags at accept.
  - Applies final negation at CALC exit.
- Iteration datapath and FSM stay in ex_muldiv.

Test Plan:
- MUL a=7, b=0xFFFFFFFD at T -> stall_o high T..T+32, done_o only at T+33, result_o=0xFFFFFFEB, busy_o low at T+34.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each done_o at T+33.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done_o at T+1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0 at T+1.
- Start DIVU at T, flush_ex=1 at T+10 -> IDLE at T+11, no done_o, result_o unchanged; new MUL 3*4 accepted at T+11 -> 12 at T+44.
- Start MUL at T, rst_ni=0 at T+5 -> from T+6 state IDLE, stall_o/busy_o/done_o=0, result_o=0; start_ex held high during reset is not accepted.
